// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command receiver.
// Optional parity is enabled with the UART_PARITY_EN macro.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_PAR,
    B_STOP
  } byte_st_t;

  typedef enum logic [1:0] {
    F_HDR,
    F_CMD,
    F_DAT,
    F_CHK
  } frm_st_t;

  localparam logic [7:0] FRAME_HDR_DEF = 8'hA5;

  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_CMOS_SEL = 8'h01;

  localparam logic [1:0] SEL_CMOS1 = 2'd0;
  localparam logic [1:0] SEL_CMOS2 = 2'd1;
  localparam logic [1:0] SEL_ALT   = 2'd2;

endpackage

// File: rtl/uart_cmd_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, byte FSM, optional even parity.
// Parity bit after D7 is present only when UART_PARITY_EN is defined.
module uart_byte_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rx,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] RL_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] RL_HALF = CW'(DIV / 2 - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_prev;
  byte_st_t      r_st;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          w_par_ok;

`ifdef UART_PARITY_EN
  logic r_par_bad;
  assign w_par_ok = !r_par_bad;
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_prev    <= 1'b1;
      r_st      <= B_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_sh      <= '0;
      byte_vld  <= 1'b0;
      byte_data <= '0;
      byte_err  <= 1'b0;
`ifdef UART_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_s1     <= uart_rx;
      r_s2     <= r_s1;
      r_prev   <= r_s2;
      byte_vld <= 1'b0;
      byte_err <= 1'b0;
      case (r_st)
        B_IDLE: begin
          if (r_prev && !r_s2) begin
            r_st  <= B_START;
            r_cnt <= RL_HALF;
          end
        end
        B_START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_s2) begin
            r_st  <= B_DATA;
            r_cnt <= RL_FULL;
            r_bit <= '0;
          end else begin
            r_st <= B_IDLE;
          end
        end
        B_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_sh  <= {r_s2, r_sh[7:1]};
            r_cnt <= RL_FULL;
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_st <= B_PAR;
`else
              r_st <= B_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        B_PAR: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_par_bad <= ^{r_sh, r_s2};
            r_cnt     <= RL_FULL;
            r_st      <= B_STOP;
          end
        end
`endif
        B_STOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_st <= B_IDLE;
            if (r_s2 && w_par_ok) begin
              byte_vld  <= 1'b1;
              byte_data <= r_sh;
            end else begin
              byte_err <= 1'b1;
            end
          end
        end
        default: r_st <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// Command frame parser: HDR CMD DAT CHK with checksum and gap timeout.
// Build with UART_PARITY_EN for 8E1 framing instead of 8N1.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD         = 115200,
  parameter logic [7:0] FRAME_HDR    = FRAME_HDR_DEF,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rx,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_data,
  output logic [1:0] cmos_sel,
  output logic       frame_err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int LIM = TIMEOUT_BITS * DIV;
  localparam int GW  = $clog2(LIM + 1);
  localparam logic [GW-1:0] LIM_V = GW'(LIM);

  logic          w_vld;
  logic          w_err;
  logic [7:0]    w_data;
  logic          w_to;
  logic [7:0]    w_sum;
  frm_st_t       r_fst;
  logic [7:0]    r_cmd;
  logic [7:0]    r_dat;
  logic [GW-1:0] r_gap;

  uart_byte_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_byte (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .uart_rx  (uart_rx),
    .byte_vld (w_vld),
    .byte_data(w_data),
    .byte_err (w_err)
  );

  assign w_to  = (r_fst != F_HDR) && (r_gap == LIM_V);
  assign w_sum = r_cmd + r_dat;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_fst     <= F_HDR;
      r_cmd     <= CMD_NOP;
      r_dat     <= '0;
      r_gap     <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_data  <= '0;
      cmos_sel  <= SEL_CMOS1;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (w_vld || r_fst == F_HDR)
        r_gap <= '0;
      else if (r_gap != LIM_V)
        r_gap <= r_gap + 1'b1;
      // Any abort cause collapses into a single error pulse.
      if (w_err || w_to) begin
        frame_err <= 1'b1;
        r_fst     <= F_HDR;
      end else if (w_vld) begin
        case (r_fst)
          F_HDR: if (w_data == FRAME_HDR) r_fst <= F_CMD;
          F_CMD: begin
            r_cmd <= w_data;
            r_fst <= F_DAT;
          end
          F_DAT: begin
            r_dat <= w_data;
            r_fst <= F_CHK;
          end
          F_CHK: begin
            r_fst <= F_HDR;
            if (w_data == w_sum) begin
              cmd_valid <= 1'b1;
              cmd_code  <= r_cmd;
              cmd_data  <= r_dat;
              if (r_cmd == CMD_CMOS_SEL && r_dat[1:0] <= SEL_ALT)
                cmos_sel <= r_dat[1:0];
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: r_fst <= F_HDR;
        endcase
      end
    end
  end

endmodule
